// File: rtl/esm_instr_streamer.sv
// Program-image feeder for the ESM reorder block: loads a short instruction image,
// streams it one word per cycle with decoded RegWrite/ALUSrc, then drains with zero bubbles.
module esm_instr_streamer #(
   parameter int Instruction_word_size = 32,
   parameter int DEPTH                 = 32,
   parameter int DRAIN_CYCLES          = 40
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load_en,
   input  logic [Instruction_word_size-1:0] load_data,
   input  logic                             clr,
   input  logic                             start,
   input  logic                             stall,
   output logic [Instruction_word_size-1:0] Instr_out,
   output logic                             RegWrite,
   output logic                             ALUSrc,
   output logic                             busy,
   output logic                             done,
   output logic [$clog2(DEPTH):0]           prog_len,
   output logic                             load_ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} state_t;

   state_t                           state_q, state_d;
   logic [LW-1:0]                    pc_q, pc_d;
   logic [LW-1:0]                    prog_len_q, prog_len_d;
   logic [DW-1:0]                    drain_q, drain_d;
   logic                             load_ovf_q, load_ovf_d;
   logic [Instruction_word_size-1:0] instr_q, instr_d;
   logic                             regwrite_q, regwrite_d;
   logic                             alusrc_q, alusrc_d;
   logic                             busy_q, busy_d;
   logic                             done_q, done_d;
   logic                             mem_we;
   logic [Instruction_word_size-1:0] cur_word;

   logic [Instruction_word_size-1:0] mem [DEPTH];

   // Returns {RegWrite, ALUSrc} for an RV32I opcode.
   function automatic logic [1:0] decode(input logic [6:0] opcode);
      case (opcode)
         7'b0010011: decode = 2'b11;
         7'b0110011: decode = 2'b10;
         7'b0110111: decode = 2'b11;
         7'b0000011: decode = 2'b11;
         7'b0100011: decode = 2'b01;
         default:    decode = 2'b00;
      endcase
   endfunction

   assign cur_word = mem[pc_q[AW-1:0]];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      prog_len_d = prog_len_q;
      drain_d    = drain_q;
      load_ovf_d = load_ovf_q;
      instr_d    = instr_q;
      regwrite_d = regwrite_q;
      alusrc_d   = alusrc_q;
      mem_we     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // load_en takes priority over clr, which takes priority over start
            if (load_en) begin
               if (prog_len_q == LW'(DEPTH)) begin
                  load_ovf_d = 1'b1;
               end else begin
                  mem_we     = 1'b1;
                  prog_len_d = prog_len_q + LW'(1);
               end
            end else if (clr) begin
               prog_len_d = '0;
               load_ovf_d = 1'b0;
            end else if (start) begin
               pc_d    = '0;
               drain_d = '0;
               state_d = (prog_len_q != '0) ? ST_STREAM : ST_DRAIN;
            end
         end
         ST_STREAM: begin
            if (!stall) begin
               instr_d                = cur_word;
               {regwrite_d, alusrc_d} = decode(cur_word[6:0]);
               pc_d                   = pc_q + LW'(1);
               if (pc_q == prog_len_q - LW'(1)) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (!stall) begin
               instr_d    = '0;
               regwrite_d = 1'b0;
               alusrc_d   = 1'b0;
               // DONE is entered on the edge after the last bubble was issued
               if (drain_q == DW'(DRAIN_CYCLES)) begin
                  state_d = ST_DONE;
               end else begin
                  drain_d = drain_q + DW'(1);
               end
            end
         end
         ST_DONE: begin
            instr_d    = '0;
            regwrite_d = 1'b0;
            alusrc_d   = 1'b0;
            if (clr) begin
               state_d    = ST_IDLE;
               prog_len_d = '0;
               load_ovf_d = 1'b0;
            end else if (start) begin
               pc_d    = '0;
               drain_d = '0;
               state_d = (prog_len_q != '0) ? ST_STREAM : ST_DRAIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         prog_len_q <= '0;
         drain_q    <= '0;
         load_ovf_q <= 1'b0;
         instr_q    <= '0;
         regwrite_q <= 1'b0;
         alusrc_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         prog_len_q <= prog_len_d;
         drain_q    <= drain_d;
         load_ovf_q <= load_ovf_d;
         instr_q    <= instr_d;
         regwrite_q <= regwrite_d;
         alusrc_q   <= alusrc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Program memory is not reset; the image survives rst but prog_len forgets it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[prog_len_q[AW-1:0]] <= load_data;
      end
   end

   assign Instr_out = instr_q;
   assign RegWrite  = regwrite_q;
   assign ALUSrc    = alusrc_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign prog_len  = prog_len_q;
   assign load_ovf  = load_ovf_q;
endmodule

// File: tb/tb_esm_instr_streamer.sv
// Directed bench for esm_instr_streamer: load, stream, stall, overflow, empty start,
// replay/clr, decode and async reset mid-stream.
module tb_esm_instr_streamer;
   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int DRAIN = 40;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           load_en = 1'b0;
   logic [W-1:0]   load_data = '0;
   logic           clr = 1'b0;
   logic           start = 1'b0;
   logic           stall = 1'b0;
   logic [W-1:0]   Instr_out;
   logic           RegWrite;
   logic           ALUSrc;
   logic           busy;
   logic           done;
   logic [2:0]     prog_len;
   logic           load_ovf;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] exp_w [4];
   logic [1:0]   exp_c [4];

   esm_instr_streamer #(
      .Instruction_word_size(W),
      .DEPTH(DEPTH),
      .DRAIN_CYCLES(DRAIN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load_en(load_en),
      .load_data(load_data),
      .clr(clr),
      .start(start),
      .stall(stall),
      .Instr_out(Instr_out),
      .RegWrite(RegWrite),
      .ALUSrc(ALUSrc),
      .busy(busy),
      .done(done),
      .prog_len(prog_len),
      .load_ovf(load_ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [W-1:0] w);
      load_en   = 1'b1;
      load_data = w;
      step();
      load_en   = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_state", 64'({busy, done, prog_len, load_ovf}), 64'({1'b0, 1'b0, 3'd0, 1'b0}));
   endtask

   // Pulses start and checks every cycle until done rises: n words from exp_w/exp_c,
   // with stall held for stall_len cycles right after word stall_idx appears.
   task automatic run_stream(input string tag, input int n, input int stall_idx, input int stall_len);
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy_at_start"}, 64'({busy, done}), 64'(2'b10));
      for (int i = 0; i < n; i++) begin
         step();
         chk({tag, "_instr"}, 64'(Instr_out), 64'(exp_w[i]));
         chk({tag, "_ctrl"}, 64'({RegWrite, ALUSrc}), 64'(exp_c[i]));
         if (i == stall_idx) begin
            stall = 1'b1;
            for (int s = 0; s < stall_len; s++) begin
               step();
               chk({tag, "_stall_hold"}, 64'({RegWrite, ALUSrc, Instr_out}), 64'({exp_c[i], exp_w[i]}));
            end
            stall = 1'b0;
         end
      end
      for (int d = 0; d < DRAIN; d++) begin
         step();
         chk({tag, "_drain"}, 64'({busy, done, RegWrite, ALUSrc, Instr_out}),
             64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
      end
      step();
      chk({tag, "_done"}, 64'({busy, done, Instr_out}), 64'({1'b0, 1'b1, 32'h0}));
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_outputs", 64'({busy, done, RegWrite, ALUSrc, Instr_out}), 64'(0));
      chk("rst_len_ovf", 64'({prog_len, load_ovf}), 64'(0));
      rst = 1'b0;
      step();

      // Free run of three words
      load_word(32'h00A00093);
      load_word(32'h01400113);
      load_word(32'h002081B3);
      chk("load3_len", 64'(prog_len), 64'(3));
      exp_w[0] = 32'h00A00093; exp_c[0] = 2'b11;
      exp_w[1] = 32'h01400113; exp_c[1] = 2'b11;
      exp_w[2] = 32'h002081B3; exp_c[2] = 2'b10;
      run_stream("free", 3, -1, 0);

      // Replay from DONE, then stall on the second word
      run_stream("replay", 3, -1, 0);
      run_stream("stall", 3, 1, 2);

      // load_en in DONE is ignored
      load_word(32'hFFFFFFFF);
      chk("done_load_ignored", 64'({done, prog_len}), 64'({1'b1, 3'd3}));
      do_clr();

      // Overflow: fifth word dropped; start together with it is ignored
      load_word(32'h00100093);
      load_word(32'h00200113);
      load_word(32'h00300193);
      load_word(32'h00400213);
      chk("full_no_ovf", 64'({prog_len, load_ovf}), 64'({3'd4, 1'b0}));
      start = 1'b1;
      load_word(32'h00500293);
      start = 1'b0;
      chk("ovf_flag", 64'({busy, prog_len, load_ovf}), 64'({1'b0, 3'd4, 1'b1}));
      exp_w[0] = 32'h00100093; exp_c[0] = 2'b11;
      exp_w[1] = 32'h00200113; exp_c[1] = 2'b11;
      exp_w[2] = 32'h00300193; exp_c[2] = 2'b11;
      exp_w[3] = 32'h00400213; exp_c[3] = 2'b11;
      run_stream("ovf", 4, -1, 0);
      do_clr();

      // Empty start goes straight to drain
      run_stream("empty", 0, -1, 0);
      do_clr();

      // Decode: LUI, STORE, LOAD, FENCE
      load_word(32'h004004B7);
      load_word(32'h0000A023);
      load_word(32'h0000A103);
      load_word(32'h0000000F);
      exp_w[0] = 32'h004004B7; exp_c[0] = 2'b11;
      exp_w[1] = 32'h0000A023; exp_c[1] = 2'b01;
      exp_w[2] = 32'h0000A103; exp_c[2] = 2'b11;
      exp_w[3] = 32'h0000000F; exp_c[3] = 2'b00;
      run_stream("decode", 4, -1, 0);
      do_clr();

      // Async reset during the second instruction
      load_word(32'h00A00093);
      load_word(32'h01400113);
      load_word(32'h002081B3);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("pre_rst_word", 64'(Instr_out), 64'(32'h01400113));
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      step();
      chk("midrst_outputs", 64'({busy, done, RegWrite, ALUSrc, Instr_out}), 64'(0));
      chk("midrst_len", 64'({prog_len, load_ovf}), 64'(0));
      run_stream("post_rst", 0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
